wave_scheduler: RTL and testbench

WAVE_SCHEDULER -- requirements
Module: wave_scheduler

---
 rtl/wave_scheduler_pkg.sv | 25 ++
 rtl/wave_scheduler_if.sv | 34 +++
 rtl/wave_scheduler_rr_arbiter.sv | 44 ++++
 rtl/wave_scheduler.sv | 173 +++++++++++++++++
 tb/tb_wave_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_scheduler_pkg.sv
// Shared types, constants and width helpers for the wave scheduler slice.
package wave_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DISPATCH,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    // Wave ID parked on the dispatch bus when a launch produces no waves.
    localparam logic [31:0] INVALID_WAVE_ID = 32'hFFFF_FFFF;

    // Bits needed to index n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wave_scheduler_if.sv
// Block-launch and wave-dispatch bus between a host and the wave scheduler.
interface wave_scheduler_if #(
    parameter int NUM_SIMDS = 4,
    parameter int WAVE_SIZE = 32
);
    logic                 block_valid;
    logic                 block_ready;
    logic [31:0]          block_id;
    logic [31:0]          num_threads;
    logic [31:0]          block_dim;
    logic [NUM_SIMDS-1:0] disp_valid;
    logic [NUM_SIMDS-1:0] disp_ready;
    logic [31:0]          disp_wave_id;
    logic [WAVE_SIZE-1:0] disp_lane_mask;
    logic [NUM_SIMDS-1:0] simd_done;
    logic                 busy;
    logic                 block_done;
    logic [31:0]          num_waves;
    logic                 err;

    // Host / SIMD side.
    modport master (
        output block_valid, block_id, num_threads, block_dim, disp_ready, simd_done,
        input  block_ready, disp_valid, disp_wave_id, disp_lane_mask, busy, block_done,
               num_waves, err
    );

    // Scheduler side.
    modport slave (
        input  block_valid, block_id, num_threads, block_dim, disp_ready, simd_done,
        output block_ready, disp_valid, disp_wave_id, disp_lane_mask, busy, block_done,
               num_waves, err
    );
endinterface

// File: rtl/wave_scheduler_rr_arbiter.sv
// Round-robin pick of the first requesting SIMD after the last one granted.
module rr_arbiter
    import wave_scheduler_pkg::*;
#(
    parameter int NUM_SIMDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SIMDS-1:0] req,
    input  logic                 advance,
    output logic [NUM_SIMDS-1:0] grant
);
    localparam int IW = idx_w(NUM_SIMDS);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gnt_idx;
    logic          found;

    // Scan requests starting at the pointer, wrapping once around.
    always_comb begin
        grant   = '0;
        gnt_idx = ptr_q;
        found   = 1'b0;
        for (int k = 0; k < NUM_SIMDS; k++) begin
            for (int i = 0; i < NUM_SIMDS; i++) begin
                if (!found && req[i] && (((int'(ptr_q) + k) % NUM_SIMDS) == i)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_idx  = IW'(i);
                end
            end
        end
    end

    // Move the search start just past the SIMD granted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (gnt_idx == IW'(NUM_SIMDS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wave_scheduler.sv
// Splits a launched thread block into waves and hands them out to SIMD slots.
module wave_scheduler
    import wave_scheduler_pkg::*;
#(
    parameter int NUM_SIMDS = 4,
    parameter int WAVE_SIZE = 32,
    parameter int SLOTS     = 2
) (
    input logic              clk,
    input logic              rst,
    wave_scheduler_if.slave  bus
);
    localparam int            OW      = cnt_w(SLOTS);
    localparam int            LW      = $clog2(WAVE_SIZE);
    localparam logic [OW-1:0] SLOTS_C = OW'(SLOTS);

    sched_state_e state_q, state_d;

    logic [31:0]          bid_q, thr_q, dim_q;
    logic [31:0]          bthreads_q, nwaves_q, disp_cnt_q, done_cnt_q;
    logic [OW-1:0]        occ_q [NUM_SIMDS];
    logic [OW-1:0]        occ_d [NUM_SIMDS];
    logic [NUM_SIMDS-1:0] offer_sel_q;
    logic [31:0]          wave_id_q;
    logic [WAVE_SIZE-1:0] mask_q;
    logic                 err_q;

    logic                 launch, bad;
    logic [63:0]          start_w;
    logic [31:0]          left, bt_calc, nw_calc;
    logic [32:0]          nw_sum;
    logic [NUM_SIMDS-1:0] acc, done_ok, req, gnt;
    logic                 accept_any, done_bad, pick;
    logic [31:0]          done_inc, disp_cnt_d, bt_src, rem;
    logic [WAVE_SIZE-1:0] mask_calc;

    assign launch             = (state_q == ST_IDLE) && bus.block_valid;
    assign bus.block_ready    = (state_q == ST_IDLE);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.block_done     = (state_q == ST_DONE);
    assign bus.disp_valid     = offer_sel_q;
    assign bus.disp_wave_id   = wave_id_q;
    assign bus.disp_lane_mask = mask_q;
    assign bus.num_waves      = nwaves_q;
    assign bus.err            = err_q;

    // Block geometry; block_id >= ceil(T/D) is tested as block_id*D >= T to avoid a divider.
    always_comb begin
        start_w = 64'(bid_q) * 64'(dim_q);
        bad     = (thr_q == '0) || (dim_q == '0) || (start_w >= 64'(thr_q));
        left    = thr_q - start_w[31:0];
        bt_calc = (left < dim_q) ? left : dim_q;
        nw_sum  = 33'(bt_calc) + 33'(WAVE_SIZE - 1);
        nw_calc = 32'(nw_sum >> LW);
    end

    // Per-SIMD occupancy update; a done on an empty SIMD is dropped and flagged.
    always_comb begin
        acc      = bus.disp_valid & bus.disp_ready;
        done_ok  = '0;
        done_bad = 1'b0;
        done_inc = '0;
        req      = '0;
        for (int i = 0; i < NUM_SIMDS; i++) begin
            occ_d[i]   = occ_q[i];
            done_ok[i] = bus.simd_done[i] && (occ_q[i] != '0);
            done_bad   = done_bad | (bus.simd_done[i] && (occ_q[i] == '0));
            done_inc   = done_inc + 32'(done_ok[i]);
            occ_d[i]   = occ_q[i] + OW'(acc[i]) - OW'(done_ok[i]);
            req[i]     = (occ_d[i] < SLOTS_C);
        end
    end

    // Next offer is formed on the edge that accepts the current one, or loads the block.
    always_comb begin
        accept_any = |acc;
        disp_cnt_d = disp_cnt_q + 32'(accept_any);
        pick       = ((state_q == ST_LOAD) && !bad && (|req)) ||
                     ((state_q == ST_DISPATCH) && (!(|offer_sel_q) || accept_any) &&
                      (disp_cnt_d < nwaves_q) && (|req));
        bt_src     = (state_q == ST_LOAD) ? bt_calc : bthreads_q;
        rem        = bt_src - (disp_cnt_d << LW);
        mask_calc  = '1;
        if (rem < 32'(WAVE_SIZE)) begin
            mask_calc = ~({WAVE_SIZE{1'b1}} << rem);
        end
    end

    rr_arbiter #(
        .NUM_SIMDS (NUM_SIMDS)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (pick),
        .grant   (gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.block_valid) state_d = ST_LOAD;
            ST_LOAD:     state_d = bad ? ST_DONE : ST_DISPATCH;
            ST_DISPATCH: if (disp_cnt_q == nwaves_q) state_d = ST_DRAIN;
            ST_DRAIN:    if (done_cnt_q == nwaves_q) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Launch capture, counters, occupancies, offer registers and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            bid_q       <= '0;
            thr_q       <= '0;
            dim_q       <= '0;
            bthreads_q  <= '0;
            nwaves_q    <= '0;
            disp_cnt_q  <= '0;
            done_cnt_q  <= '0;
            offer_sel_q <= '0;
            wave_id_q   <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_SIMDS; i++) begin
                occ_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SIMDS; i++) begin
                occ_q[i] <= occ_d[i];
            end
            disp_cnt_q <= disp_cnt_d;
            done_cnt_q <= done_cnt_q + done_inc;
            err_q      <= err_q | done_bad;
            if (pick) begin
                offer_sel_q <= gnt;
                wave_id_q   <= disp_cnt_d;
                mask_q      <= mask_calc;
            end else if (accept_any) begin
                offer_sel_q <= '0;
            end
            if (launch) begin
                bid_q      <= bus.block_id;
                thr_q      <= bus.num_threads;
                dim_q      <= bus.block_dim;
                disp_cnt_q <= '0;
                done_cnt_q <= '0;
                err_q      <= 1'b0;
            end
            if (state_q == ST_LOAD) begin
                if (bad) begin
                    nwaves_q  <= '0;
                    err_q     <= 1'b1;
                    wave_id_q <= INVALID_WAVE_ID;
                end else begin
                    nwaves_q   <= nw_calc;
                    bthreads_q <= bt_calc;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_scheduler.sv
// Directed scoreboard bench for wave_scheduler (4 SIMDs, 32 lanes, 2 slots).
module tb_wave_scheduler;
    localparam int NS = 4;
    localparam int WS = 32;
    localparam int SL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wave_scheduler_if #(.NUM_SIMDS(NS), .WAVE_SIZE(WS)) bus ();

    wave_scheduler #(.NUM_SIMDS(NS), .WAVE_SIZE(WS), .SLOTS(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            simd;
        logic [31:0]   id;
        logic [WS-1:0] mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   done_pulses = 0;

    logic          hold_pend = 1'b0;
    logic [NS-1:0] hold_v;
    logic [31:0]   hold_id;
    logic [WS-1:0] hold_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int simd, input logic [31:0] id, input logic [WS-1:0] mask);
        exp_t e;
        e.simd = simd;
        e.id   = id;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.block_valid = 1'b0;
        bus.block_id    = '0;
        bus.num_threads = '0;
        bus.block_dim   = '0;
        bus.disp_ready  = '0;
        bus.simd_done   = '0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        acc_cnt     = 0;
        done_pulses = 0;
    endtask

    task automatic launch(input logic [31:0] id, input logic [31:0] thr, input logic [31:0] dim);
        chk("launch_ready", bus.block_ready, 1);
        bus.block_valid = 1'b1;
        bus.block_id    = id;
        bus.num_threads = thr;
        bus.block_dim   = dim;
        step();
        bus.block_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [NS-1:0] m);
        bus.simd_done = m;
        step();
        bus.simd_done = '0;
    endtask

    task automatic wait_acc(input string name, input int n, input int budget);
        int k = 0;
        while (acc_cnt < n && k < budget) begin
            step();
            k++;
        end
        chk({"accepts_", name}, 64'(acc_cnt), 64'(n));
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!bus.block_done && k < budget) begin
            step();
            k++;
        end
        chk({"block_done_", name}, bus.block_done, 1);
    endtask

    // Monitor: scores accepted offers against the queue and checks held offers stay put.
    always @(negedge clk) begin
        if (hold_pend) begin
            chk("hold_valid", bus.disp_valid, hold_v);
            chk("hold_id", bus.disp_wave_id, hold_id);
            chk("hold_mask", bus.disp_lane_mask, hold_m);
        end
        if (!rst && bus.block_done) done_pulses++;
        if (!rst && |(bus.disp_valid & bus.disp_ready)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_offer: got simd 0x%0h id %0d, expected no offer",
                         bus.disp_valid, bus.disp_wave_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("offer_simd", bus.disp_valid, 64'(1 << mon_e.simd));
                chk("offer_id", bus.disp_wave_id, mon_e.id);
                chk("offer_mask", bus.disp_lane_mask, mon_e.mask);
            end
            acc_cnt++;
        end
        hold_pend = !rst && (|bus.disp_valid) && !(|(bus.disp_valid & bus.disp_ready));
        hold_v    = bus.disp_valid;
        hold_id   = bus.disp_wave_id;
        hold_m    = bus.disp_lane_mask;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        do_reset();
        chk("rst_block_ready", bus.block_ready, 1);
        chk("rst_disp_valid", bus.disp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_block_done", bus.block_done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_num_waves", bus.num_waves, 0);
        chk("rst_wave_id", bus.disp_wave_id, 0);
        chk("rst_lane_mask", bus.disp_lane_mask, 0);

        // 100 threads, 64 per block, block 1: 36 threads -> 2 waves, last has 4 lanes.
        do_reset();
        bus.disp_ready = '1;
        push_exp(0, 0, 32'hFFFF_FFFF);
        push_exp(1, 1, 32'h0000_000F);
        launch(1, 100, 64);
        chk("t1_busy_load", bus.busy, 1);
        chk("t1_ready_load", bus.block_ready, 0);
        step();
        chk("t1_num_waves", bus.num_waves, 2);
        wait_acc("t1", 2, 20);
        pulse_done(4'b0011);
        wait_done("t1", 10);
        chk("t1_err", bus.err, 0);
        step();
        chk("t1_idle_ready", bus.block_ready, 1);
        chk("t1_queue_empty", 64'(exp_q.size()), 0);
        chk("t1_done_pulses", 64'(done_pulses), 1);

        // 256 threads in one block: 8 waves round-robin until every slot is full.
        do_reset();
        bus.disp_ready = '1;
        for (int w = 0; w < 8; w++) push_exp(w % NS, w, 32'hFFFF_FFFF);
        launch(0, 256, 256);
        step();
        chk("t2_num_waves", bus.num_waves, 8);
        wait_acc("t2", 8, 40);
        for (int k = 0; k < 5; k++) step();
        chk("t2_drain_busy", bus.busy, 1);
        chk("t2_drain_no_offer", bus.disp_valid, 0);
        chk("t2_drain_no_done", 64'(done_pulses), 0);
        for (int i = 0; i < 8; i++) pulse_done(4'(1 << (i % NS)));
        wait_done("t2", 10);
        step();
        step();
        chk("t2_one_pulse", 64'(done_pulses), 1);
        chk("t2_err", bus.err, 0);

        // Back-pressure: offer held for 5 cycles, accepted on the 6th.
        do_reset();
        push_exp(0, 0, 32'hFFFF_FFFF);
        push_exp(1, 1, 32'hFFFF_FFFF);
        launch(0, 64, 64);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_valid", bus.disp_valid, 4'b0001);
            chk("t3_stall_id", bus.disp_wave_id, 0);
            step();
        end
        chk("t3_no_accept_yet", 64'(acc_cnt), 0);
        bus.disp_ready = '1;
        step();
        chk("t3_accept_cycle6", 64'(acc_cnt), 1);
        wait_acc("t3", 2, 10);
        pulse_done(4'b0011);
        wait_done("t3", 10);
        step();

        // Four dones in one cycle together with an accept on SIMD2.
        do_reset();
        bus.disp_ready = '1;
        for (int w = 0; w < 8; w++) push_exp(w % NS, w, 32'hFFFF_FFFF);
        launch(0, 256, 256);
        begin
            int k = 0;
            while (!(bus.disp_valid == 4'b0100 && bus.disp_wave_id == 6) && k < 40) begin
                step();
                k++;
            end
        end
        chk("t4_wave6_simd2", {bus.disp_valid, bus.disp_wave_id}, {4'b0100, 32'd6});
        pulse_done(4'b1111);
        chk("t4_err_after_multi", bus.err, 0);
        wait_acc("t4", 8, 20);
        pulse_done(4'b1111);
        wait_done("t4", 10);
        chk("t4_err_final", bus.err, 0);
        step();

        // Out-of-range block: error path, no offers, done two cycles after launch.
        do_reset();
        bus.disp_ready = '1;
        launch(5, 100, 64);
        chk("t5_no_done_load", bus.block_done, 0);
        step();
        chk("t5_block_done", bus.block_done, 1);
        chk("t5_err", bus.err, 1);
        chk("t5_num_waves", bus.num_waves, 0);
        chk("t5_no_offer", bus.disp_valid, 0);
        step();
        chk("t5_done_cleared", bus.block_done, 0);
        chk("t5_err_sticky", bus.err, 1);
        push_exp(0, 0, 32'hFFFF_FFFF);
        launch(0, 32, 32);
        chk("t5_err_cleared", bus.err, 0);
        wait_acc("t5", 1, 10);
        pulse_done(4'b0001);
        wait_done("t5", 10);
        step();
        pulse_done(4'b0001);
        chk("t5_spurious_done_err", bus.err, 1);

        // Reset in the middle of dispatch, then a clean restart.
        do_reset();
        bus.disp_ready = '1;
        for (int w = 0; w < 3; w++) push_exp(w, w, 32'hFFFF_FFFF);
        launch(0, 256, 256);
        wait_acc("t6_pre", 3, 20);
        rst = 1'b1;
        bus.disp_ready = '0;
        step();
        chk("t6_disp_valid", bus.disp_valid, 0);
        chk("t6_block_ready", bus.block_ready, 1);
        chk("t6_busy", bus.busy, 0);
        chk("t6_num_waves", bus.num_waves, 0);
        chk("t6_block_done", bus.block_done, 0);
        rst = 1'b0;
        step();
        chk("t6_no_done_pulse", 64'(done_pulses), 0);
        acc_cnt = 0;
        bus.disp_ready = '1;
        push_exp(0, 0, 32'hFFFF_FFFF);
        push_exp(1, 1, 32'hFFFF_FFFF);
        launch(0, 64, 64);
        wait_acc("t6_post", 2, 20);
        chk("t6_queue_empty", 64'(exp_q.size()), 0);
        pulse_done(4'b0011);
        wait_done("t6", 10);
        step();
        chk("t6_one_pulse", 64'(done_pulses), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
